// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

  localparam int CNT_W = cnt_width(DW_DEF);

endpackage

// File: rtl/seq_divider_restoring_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// conditionally subtract the divisor using a ripple of FullAdder cells.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module restoring_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   r_o,
  output logic          q_bit_o
);
  logic [VW:0]   t;
  logic [VW:0]   sub_b;
  logic [VW:0]   diff;
  logic [VW+1:0] carry;
  // R stays below the divisor between steps, so its top bit is always zero.
  logic          unused_r_msb;

  assign unused_r_msb = r_i[VW];
  assign t            = {r_i[VW-1:0], q_msb_i};
  assign sub_b        = ~{1'b0, divisor_i};
  assign carry[0]     = 1'b1;

  generate
    for (genvar gi = 0; gi <= VW; gi++) begin : g_fa
      FullAdder u_fa (
        .a   (t[gi]),
        .b   (sub_b[gi]),
        .cin (carry[gi]),
        .sum (diff[gi]),
        .cout(carry[gi+1])
      );
    end
  endgenerate

  // Carry-out of T + ~D + 1 is the T >= D decision.
  assign q_bit_o = carry[VW+1];
  assign r_o     = q_bit_o ? diff : t;
endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per clock,
// start/done handshake, registered results held until the next run completes.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  localparam int            CW   = cnt_width(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [VW:0]   r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] dvs_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;
  logic          dbz_q;
  logic          q_bit;
  logic          accept;
  logic          div_zero;
  logic          last_iter;

  assign accept    = start && (state_q != RUN);
  assign div_zero  = (dvs_q == '0);
  assign last_iter = div_zero || (cnt_q == LAST);
  assign q_d       = {q_q[DW-2:0], q_bit};

  restoring_step #(.VW(VW)) u_step (
    .r_i      (r_q),
    .q_msb_i  (q_q[DW-1]),
    .divisor_i(dvs_q),
    .r_o      (r_d),
    .q_bit_o  (q_bit)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // On divide-by-zero Q still holds the untouched dividend, so its low bits
  // are the remainder to report.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      r_q   <= '0;
      q_q   <= dividend;
      dvs_q <= divisor;
      dbz_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (div_zero) begin
        quot_q <= '1;
        rem_q  <= q_q[VW-1:0];
        dbz_q  <= 1'b1;
      end else begin
        r_q   <= r_d;
        q_q   <= q_d;
        cnt_q <= cnt_q + CW'(1);
        if (last_iter) begin
          quot_q <= q_d;
          rem_q  <= r_d[VW-1:0];
        end
      end
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
